sram_arbiter: RTL and testbench

Shares the single external 256K×16 SRAM port between three requesters:
- the VGA pixel fetcher (read-only, real-time);
- the mic12 decoder datapath (read/write);
- the UART loader (write-only).

It sits between those units and the SRAM controller in the top level. It issues at most one SRAM access per clock and routes each read word back to its originator after the fixed SRAM read latency. Optional grant statistics support bandwidth debugging.

---
 rtl/sram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
//
// Shares the single external 256Kx16 SRAM port between three requesters:
//   port 0 - VGA pixel fetcher (read-only, real-time, highest priority)
//   port 1 - mic12 decoder datapath (read/write)
//   port 2 - UART loader (write-only)
// At most one access is accepted per clock. The zero-latency grant decides
// which request is accepted at the next edge. Read words are routed back to
// their originator after READ_LATENCY cycles, in issue order.
//
// Optional feature macro: SRAM_ARB_STATS_EN
//   When defined, adds per-port saturating grant counters (grant_count_o)
//   and the largest starvation-counter value seen (max_wait_o).
//
// Ports:
//   Clock_50           system clock
//   Reset              synchronous, active-high
//   req_i[2:0]         per-port request, held until granted
//   we_i[2:0]          per-port write enable (bit 0 and bit 2 ignored)
//   addr_i             per-port address, port p at [p*ADDR_W +: ADDR_W]
//   wdata_i            per-port write data, port p at [p*DATA_W +: DATA_W]
//   gnt_o[2:0]         combinational one-hot/zero grant
//   rvalid_o[2:0]      one-hot/zero read-return strobe
//   rdata_o            registered read data, shared by all ports
//   SRAM_address_o     registered SRAM address
//   SRAM_write_data_o  registered SRAM write data
//   SRAM_we_n_o        registered SRAM write enable, active-low
//   SRAM_read_data_i   read data from the SRAM controller
module sram_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  Clock_50,
    input  logic                  Reset,
    input  logic [2:0]            req_i,
    input  logic [2:0]            we_i,
    input  logic [3*ADDR_W-1:0]   addr_i,
    input  logic [3*DATA_W-1:0]   wdata_i,
    output logic [2:0]            gnt_o,
    output logic [2:0]            rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [ADDR_W-1:0]     SRAM_address_o,
    output logic [DATA_W-1:0]     SRAM_write_data_o,
    output logic                  SRAM_we_n_o,
    input  logic [DATA_W-1:0]     SRAM_read_data_i
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [3*32-1:0]       grant_count_o,
    output logic [7:0]            max_wait_o
`endif
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    // Round-robin pointer naming the favoured low-priority port.
    typedef enum logic {
        FAV_DEC  = 1'b0,
        FAV_UART = 1'b1
    } rr_t;

    rr_t               rr_ptr;
    rr_t               rr_next;
    logic [7:0]        starve_cnt;
    logic [7:0]        starve_next;
    logic [2:0]        rr_pick;
    logic              low_pending;
    logic              forced;
    logic [2:0]        gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_write;
    logic [2:0]        new_tag;
    logic [2:0]        tags [READ_LATENCY];
    logic [2:0]        tail;

    // Port 0 always reads and port 2 always writes, so these bits carry no
    // information.
    logic unused_we;
    assign unused_we = &{1'b0, we_i[0], we_i[2]};

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            rr_ptr     <= FAV_DEC;
            starve_cnt <= '0;
        end else begin
            rr_ptr     <= rr_next;
            starve_cnt <= starve_next;
        end
    end

    // Grant decision. Once the starvation counter reaches the limit, the
    // round-robin winner among ports 1/2 overrides the VGA port for one cycle.
    always_comb begin
        rr_pick     = 3'b000;
        low_pending = req_i[1] | req_i[2];
        if (rr_ptr == FAV_DEC) begin
            if (req_i[1])      rr_pick = 3'b010;
            else if (req_i[2]) rr_pick = 3'b100;
        end else begin
            if (req_i[2])      rr_pick = 3'b100;
            else if (req_i[1]) rr_pick = 3'b010;
        end

        forced = low_pending && (starve_cnt >= LIMIT);

        gnt = 3'b000;
        if (Reset)         gnt = 3'b000;
        else if (forced)   gnt = rr_pick;
        else if (req_i[0]) gnt = 3'b001;
        else               gnt = rr_pick;

        rr_next = rr_ptr;
        if (gnt[1])      rr_next = FAV_UART;
        else if (gnt[2]) rr_next = FAV_DEC;

        starve_next = starve_cnt;
        if (gnt[1] || gnt[2] || !low_pending)
            starve_next = '0;
        else if (gnt[0] && starve_cnt != 8'hFF)
            starve_next = starve_cnt + 8'd1;
    end

    assign gnt_o = gnt;

    // Mux the winning port's address, data and write flag onto the SRAM side.
    always_comb begin
        sel_addr  = addr_i[0 +: ADDR_W];
        sel_wdata = wdata_i[0 +: DATA_W];
        sel_write = 1'b0;
        if (gnt[1]) begin
            sel_addr  = addr_i[ADDR_W +: ADDR_W];
            sel_wdata = wdata_i[DATA_W +: DATA_W];
            sel_write = we_i[1];
        end else if (gnt[2]) begin
            sel_addr  = addr_i[2*ADDR_W +: ADDR_W];
            sel_wdata = wdata_i[2*DATA_W +: DATA_W];
            sel_write = 1'b1;
        end
        new_tag = sel_write ? 3'b000 : gnt;
    end

    // With no grant only the write strobe drops; address and data hold.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            SRAM_address_o    <= '0;
            SRAM_write_data_o <= '0;
            SRAM_we_n_o       <= 1'b1;
        end else if (|gnt) begin
            SRAM_address_o    <= sel_addr;
            SRAM_write_data_o <= sel_wdata;
            SRAM_we_n_o       <= ~sel_write;
        end else begin
            SRAM_we_n_o       <= 1'b1;
        end
    end

    // Each tag slot holds the one-hot originator of a read; all-zero marks a
    // write or an idle cycle. Reset empties the pipe so reads issued before
    // it never return.
    assign tail = tags[READ_LATENCY-1];

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            for (int i = 0; i < READ_LATENCY; i++) tags[i] <= '0;
            rvalid_o <= '0;
            rdata_o  <= '0;
        end else begin
            tags[0] <= new_tag;
            for (int i = 1; i < READ_LATENCY; i++) tags[i] <= tags[i-1];
            rvalid_o <= tail;
            if (|tail) rdata_o <= SRAM_read_data_i;
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [31:0] grant_count [3];
    logic [7:0]  max_wait;

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            for (int p = 0; p < 3; p++) grant_count[p] <= '0;
            max_wait <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (gnt[p] && grant_count[p] != 32'hFFFF_FFFF)
                    grant_count[p] <= grant_count[p] + 32'd1;
            end
            if (starve_cnt > max_wait) max_wait <= starve_cnt;
        end
    end

    assign grant_count_o = {grant_count[2], grant_count[1], grant_count[0]};
    assign max_wait_o    = max_wait;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//
// Directed testbench for sram_arbiter. Each stimulus cycle drives the
// requests, checks the combinational grant against a hand-written value
// and checks the SRAM-side registers against a small model. Every granted
// read pushes its expected return (port, word, cycle) onto a queue that an
// independent monitor pops whenever rvalid_o is seen.
module tb_sram_arbiter;

    localparam int ADDR_W       = 18;
    localparam int DATA_W       = 16;
    localparam int READ_LATENCY = 2;
    localparam int STARVE_LIMIT = 16;

    localparam logic [ADDR_W-1:0] A0 = 18'd146944;
    localparam logic [ADDR_W-1:0] A1 = 18'h1_0F0F;
    localparam logic [ADDR_W-1:0] A2 = 18'h2_2222;
    localparam logic [ADDR_W-1:0] B0 = 18'h0_0123;
    localparam logic [ADDR_W-1:0] B1 = 18'h3_0456;
    localparam logic [ADDR_W-1:0] B2 = 18'h1_7789;
    localparam logic [DATA_W-1:0] W0 = 16'h1111;
    localparam logic [DATA_W-1:0] W1 = 16'hBEEF;
    localparam logic [DATA_W-1:0] W2 = 16'hCAFE;

    logic                Clock_50;
    logic                Reset;
    logic [2:0]          req_i;
    logic [2:0]          we_i;
    logic [3*ADDR_W-1:0] addr_i;
    logic [3*DATA_W-1:0] wdata_i;
    logic [2:0]          gnt_o;
    logic [2:0]          rvalid_o;
    logic [DATA_W-1:0]   rdata_o;
    logic [ADDR_W-1:0]   SRAM_address_o;
    logic [DATA_W-1:0]   SRAM_write_data_o;
    logic                SRAM_we_n_o;
    logic [DATA_W-1:0]   SRAM_read_data_i;
`ifdef SRAM_ARB_STATS_EN
    logic [3*32-1:0]     grant_count_o;
    logic [7:0]          max_wait_o;
`endif

    sram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .READ_LATENCY(READ_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .Clock_50(Clock_50),
        .Reset(Reset),
        .req_i(req_i),
        .we_i(we_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .gnt_o(gnt_o),
        .rvalid_o(rvalid_o),
        .rdata_o(rdata_o),
        .SRAM_address_o(SRAM_address_o),
        .SRAM_write_data_o(SRAM_write_data_o),
        .SRAM_we_n_o(SRAM_we_n_o),
        .SRAM_read_data_i(SRAM_read_data_i)
`ifdef SRAM_ARB_STATS_EN
        ,
        .grant_count_o(grant_count_o),
        .max_wait_o(max_wait_o)
`endif
    );

    typedef struct {
        logic [2:0]        port;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    int                checks = 0;
    int                errors = 0;
    int                cyc    = 0;
    logic [ADDR_W-1:0] addr_d = '0;
    logic [ADDR_W-1:0] mdl_addr = '0;
    logic [DATA_W-1:0] mdl_data = '0;
    logic              mdl_we_n = 1'b1;

    initial Clock_50 = 1'b0;
    always #5 Clock_50 = ~Clock_50;

    always @(posedge Clock_50) cyc <= cyc + 1;

    // SRAM model: a word derived from its address, plus one fixed test word.
    function automatic logic [DATA_W-1:0] sram_word(input logic [ADDR_W-1:0] a);
        if (a == 18'd146944) return 16'hA5C3;
        return a[15:0] ^ 16'h3C5A;
    endfunction

    // With READ_LATENCY=2 the word is sampled one cycle after the address
    // first appears, so the model delays the address by one clock.
    always @(posedge Clock_50) addr_d <= SRAM_address_o;
    assign SRAM_read_data_i = sram_word(addr_d);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One stimulus cycle: drive inputs after the edge, check at the falling
    // edge, then record the read expectation and advance the SRAM-side model.
    task automatic applyStimulus(input logic rst, input logic [2:0] req,
                                 input logic [2:0] we,
                                 input logic [3*ADDR_W-1:0] addrs,
                                 input logic [3*DATA_W-1:0] wdatas,
                                 input logic [2:0] exp_gnt, input string name);
        exp_t e;
        @(posedge Clock_50);
        #1;
        if (Reset) exp_q.delete();
        Reset   = rst;
        req_i   = req;
        we_i    = we;
        addr_i  = addrs;
        wdata_i = wdatas;
        @(negedge Clock_50);
        checkOutput({name, " gnt"}, 32'(gnt_o), 32'(exp_gnt));
        checkOutput({name, " sram_addr"}, 32'(SRAM_address_o), 32'(mdl_addr));
        checkOutput({name, " sram_wdata"}, 32'(SRAM_write_data_o), 32'(mdl_data));
        checkOutput({name, " sram_we_n"}, 32'(SRAM_we_n_o), 32'(mdl_we_n));
        e.due = cyc + 1 + READ_LATENCY;
        if (rst) begin
            mdl_addr = '0; mdl_data = '0; mdl_we_n = 1'b1;
        end else if (exp_gnt[0]) begin
            mdl_addr = addrs[0 +: ADDR_W]; mdl_data = wdatas[0 +: DATA_W]; mdl_we_n = 1'b1;
            e.port = 3'b001; e.data = sram_word(mdl_addr);
            exp_q.push_back(e);
        end else if (exp_gnt[1]) begin
            mdl_addr = addrs[ADDR_W +: ADDR_W]; mdl_data = wdatas[DATA_W +: DATA_W];
            mdl_we_n = ~we[1];
            if (!we[1]) begin
                e.port = 3'b010; e.data = sram_word(mdl_addr);
                exp_q.push_back(e);
            end
        end else if (exp_gnt[2]) begin
            mdl_addr = addrs[2*ADDR_W +: ADDR_W]; mdl_data = wdatas[2*DATA_W +: DATA_W];
            mdl_we_n = 1'b0;
        end else begin
            mdl_we_n = 1'b1;
        end
    endtask

    // Monitor: every return must match the oldest outstanding read, and no
    // expected read may pass its due cycle unseen.
    always @(negedge Clock_50) begin
        if (rvalid_o !== 3'b000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rvalid: got rvalid=%b rdata=%h, expected no return (cycle %0d)",
                         rvalid_o, rdata_o, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("rvalid_port", 32'(rvalid_o), 32'(mon_e.port));
                checkOutput("rdata", 32'(rdata_o), 32'(mon_e.data));
                checkOutput("return_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missing_rvalid: got none, expected port %b data %h at cycle %0d",
                     mon_e.port, mon_e.data, mon_e.due);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3*ADDR_W-1:0] aset;
        logic [3*ADDR_W-1:0] bset;
        logic [3*DATA_W-1:0] wset;
        aset = {A2, A1, A0};
        bset = {B2, B1, B0};
        wset = {W2, W1, W0};

        Reset   = 1'b1;
        req_i   = 3'b000;
        we_i    = 3'b000;
        addr_i  = '0;
        wdata_i = '0;

        // Reset held two cycles with all requests active.
        applyStimulus(1'b1, 3'b111, 3'b000, aset, wset, 3'b000, "reset1");
        checkOutput("reset1 rvalid", 32'(rvalid_o), 32'd0);
        applyStimulus(1'b1, 3'b111, 3'b000, aset, wset, 3'b000, "reset2");
        checkOutput("reset2 rvalid", 32'(rvalid_o), 32'd0);

        // First grant right after reset: VGA read of the A5C3 word.
        applyStimulus(1'b0, 3'b111, 3'b000, aset, wset, 3'b001, "vga_read");

        // Round-robin between ports 1 and 2 with VGA idle.
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 3'b110, 3'b000, aset, wset,
                          (i % 2 == 0) ? 3'b010 : 3'b100, "round_robin");
        applyStimulus(1'b0, 3'b000, 3'b000, aset, wset, 3'b000, "idle_a");

        // Decoder write.
        applyStimulus(1'b0, 3'b010, 3'b010, bset, wset, 3'b010, "dec_write");

        // Starvation: VGA saturating, decoder pending.
        for (int i = 1; i <= STARVE_LIMIT; i++)
            applyStimulus(1'b0, 3'b011, 3'b000, bset, wset, 3'b001, "starve_vga");
        applyStimulus(1'b0, 3'b011, 3'b000, bset, wset, 3'b010, "starve_forced");
        applyStimulus(1'b0, 3'b011, 3'b000, bset, wset, 3'b001, "starve_after");
        applyStimulus(1'b0, 3'b000, 3'b000, bset, wset, 3'b000, "idle_b");

        // Starvation with both low ports pending; pointer now favours UART.
        for (int i = 1; i <= STARVE_LIMIT; i++)
            applyStimulus(1'b0, 3'b111, 3'b111, aset, wset, 3'b001, "starve2_vga");
        applyStimulus(1'b0, 3'b111, 3'b111, aset, wset, 3'b100, "starve2_forced");
        applyStimulus(1'b0, 3'b111, 3'b111, aset, wset, 3'b001, "starve2_after");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 3'b000, 3'b000, aset, wset, 3'b000, "drain_a");

        // Reset one cycle after a decoder read is granted.
        applyStimulus(1'b0, 3'b010, 3'b000, bset, wset, 3'b010, "pre_reset_read");
        applyStimulus(1'b1, 3'b010, 3'b000, bset, wset, 3'b000, "mid_reset");

`ifdef SRAM_ARB_STATS_EN
        for (int i = 0; i < 100; i++)
            applyStimulus(1'b0, 3'b100, 3'b000, bset, wset, 3'b100, "stats_write");
        applyStimulus(1'b0, 3'b000, 3'b000, bset, wset, 3'b000, "stats_idle");
        checkOutput("stats port2", grant_count_o[64 +: 32], 32'd100);
        checkOutput("stats port1", grant_count_o[32 +: 32], 32'd0);
        checkOutput("stats port0", grant_count_o[0 +: 32], 32'd0);
        checkOutput("stats max_wait", 32'(max_wait_o), 32'd0);
`endif

        applyStimulus(1'b0, 3'b010, 3'b000, aset, wset, 3'b010, "post_reset_read");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 3'b000, 3'b000, aset, wset, 3'b000, "drain_b");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clock_50);
        checkOutput("outstanding_reads", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
